// File: rtl/ieeedrv_track_mgr.sv
// ieeedrv_track_mgr
//   Track buffer manager for the 4040/8250 IEEE drive cores. Each of SUBDRV
//   drive units owns one track buffer in the SD bridge. Units are scanned
//   round-robin; the first unit with work gets a single block transfer
//   (write-back, initial load after mount, or track change load). Dirty
//   buffers are written back before a track change, on an explicit flush and
//   on unmount. A missing bridge acknowledge is retried and finally reported
//   as a sticky per-unit error.
//
// Ports
//   clk_sys, reset     system clock, synchronous active-high reset
//   ce                 clock enable for the acknowledge timeout counter
//   drv_type           0 = 8250 geometry, 1 = 4040 geometry
//   mounted[u]         image mounted on unit u
//   req_trk[u]         track wanted by unit u's head logic (1-based)
//   dirty_set[u]       pulse: unit u modified its buffer
//   flush_req[u]       pulse: write unit u's buffer back if dirty
//   geom_trk           track being looked up in the geometry table
//   geom_lba, geom_cnt start LBA / sectors-1 of geom_trk (same cycle)
//   sd_lba[u], sd_blk_cnt[u], sd_rd[u], sd_wr[u], sd_ack[u]
//                      block transfer interface of unit u's buffer
//   cur_trk[u]         track resident in unit u's buffer, 8'hFF = none
//   busy[u], dirty[u], err[u]
//                      transfer in progress / unsaved data / retries exhausted
module ieeedrv_track_mgr #(
  parameter int         SUBDRV        = 2,
  parameter logic [7:0] INIT_TRK_8250 = 8'd39,
  parameter logic [7:0] INIT_TRK_4040 = 8'd18,
  parameter int         TIMEOUT       = 4095,
  parameter int         RETRIES       = 2
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ce,
  input  logic                          drv_type,
  input  logic [SUBDRV-1:0]             mounted,
  input  logic [SUBDRV-1:0][7:0]        req_trk,
  input  logic [SUBDRV-1:0]             dirty_set,
  input  logic [SUBDRV-1:0]             flush_req,
  output logic [7:0]                    geom_trk,
  input  logic [31:0]                   geom_lba,
  input  logic [5:0]                    geom_cnt,
  output logic [SUBDRV-1:0][31:0]       sd_lba,
  output logic [SUBDRV-1:0][5:0]        sd_blk_cnt,
  output logic [SUBDRV-1:0]             sd_rd,
  output logic [SUBDRV-1:0]             sd_wr,
  input  logic [SUBDRV-1:0]             sd_ack,
  output logic [SUBDRV-1:0][7:0]        cur_trk,
  output logic [SUBDRV-1:0]             busy,
  output logic [SUBDRV-1:0]             dirty,
  output logic [SUBDRV-1:0]             err
);

  localparam int          UW        = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;
  localparam logic [11:0] TMO_LAST  = 12'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);
  localparam logic [7:0]  NO_TRK    = 8'hFF;

  typedef enum logic [2:0] {S_SCAN, S_ISSUE, S_WAIT_ACK, S_XFER, S_DONE} state_t;
  typedef enum logic [1:0] {OP_WB, OP_INIT, OP_LOAD} op_t;

  state_t            state;
  op_t               op;
  logic [UW-1:0]     rr;
  logic [7:0]        tgt;
  logic [11:0]       tmo;
  logic [3:0]        retry;
  logic [SUBDRV-1:0] mounted_q;
  logic [SUBDRV-1:0] pend_init;
  logic [SUBDRV-1:0] flush_pend;

  logic       trk_miss;
  logic       want_wb;
  logic       want_init;
  logic       want_load;
  logic [7:0] init_trk;

  function automatic logic [UW-1:0] rr_inc(input logic [UW-1:0] r);
    if (r == UW'(SUBDRV - 1)) return '0;
    return r + 1'b1;
  endfunction

  // Work decode for the unit under the round-robin pointer only.
  assign trk_miss  = (req_trk[rr] != cur_trk[rr]);
  assign want_wb   = dirty[rr] && (cur_trk[rr] != NO_TRK) &&
                     (flush_pend[rr] || trk_miss || pend_init[rr] || !mounted[rr]);
  assign want_init = pend_init[rr] && mounted[rr];
  assign want_load = mounted[rr] && trk_miss && (req_trk[rr] != 8'd0);
  assign init_trk  = drv_type ? INIT_TRK_4040 : INIT_TRK_8250;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_SCAN;
      op         <= OP_LOAD;
      rr         <= '0;
      tgt        <= '0;
      tmo        <= '0;
      retry      <= '0;
      mounted_q  <= '0;
      pend_init  <= '1;
      flush_pend <= '0;
      geom_trk   <= '0;
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      busy       <= '0;
      dirty      <= '0;
      err        <= '0;
      for (int i = 0; i < SUBDRV; i++) cur_trk[i] <= NO_TRK;
    end else begin
      mounted_q <= mounted;

      // Event capture runs in every state; the FSM assignments below come
      // later in the block so a completing transfer overrides a same-cycle
      // event on the unit it owns.
      for (int i = 0; i < SUBDRV; i++) begin
        if (mounted[i] && !mounted_q[i]) begin
          pend_init[i] <= 1'b1;
          err[i]       <= 1'b0;
        end
        if (dirty_set[i]) dirty[i] <= 1'b1;
        if ((flush_req[i] || (mounted_q[i] && !mounted[i])) && dirty[i])
          flush_pend[i] <= 1'b1;
      end

      case (state)
        S_SCAN: begin
          retry <= '0;
          if (want_wb) begin
            op       <= OP_WB;
            tgt      <= cur_trk[rr];
            geom_trk <= cur_trk[rr];
            state    <= S_ISSUE;
          end else if (want_init) begin
            op       <= OP_INIT;
            tgt      <= init_trk;
            geom_trk <= init_trk;
            state    <= S_ISSUE;
          end else if (want_load) begin
            op       <= OP_LOAD;
            tgt      <= req_trk[rr];
            geom_trk <= req_trk[rr];
            state    <= S_ISSUE;
          end else begin
            // An unmounted unit with nothing to save forgets its track.
            if (!mounted[rr]) begin
              cur_trk[rr]   <= NO_TRK;
              pend_init[rr] <= 1'b1;
            end
            rr <= rr_inc(rr);
          end
        end

        // geom_trk was registered on leaving SCAN, so the geometry answer
        // is valid throughout this cycle (and again on every retry).
        S_ISSUE: begin
          sd_lba[rr]     <= geom_lba;
          sd_blk_cnt[rr] <= geom_cnt;
          if (op == OP_WB) sd_wr[rr] <= 1'b1;
          else             sd_rd[rr] <= 1'b1;
          busy[rr] <= 1'b1;
          tmo      <= '0;
          state    <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (sd_ack[rr]) begin
            sd_rd[rr] <= 1'b0;
            sd_wr[rr] <= 1'b0;
            state     <= S_XFER;
          end else if (ce) begin
            if (tmo == TMO_LAST) begin
              // Request drops here; returning through ISSUE keeps it low
              // for one cycle before it is raised again.
              sd_rd[rr] <= 1'b0;
              sd_wr[rr] <= 1'b0;
              if (retry == RETRY_MAX) begin
                err[rr]        <= 1'b1;
                busy[rr]       <= 1'b0;
                dirty[rr]      <= 1'b0;
                flush_pend[rr] <= 1'b0;
                pend_init[rr]  <= 1'b0;
                cur_trk[rr]    <= NO_TRK;
                rr             <= rr_inc(rr);
                state          <= S_SCAN;
              end else begin
                retry <= retry + 1'b1;
                state <= S_ISSUE;
              end
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end

        // Entered with sd_ack high, so a low ack is its falling edge.
        S_XFER: begin
          if (!sd_ack[rr]) state <= S_DONE;
        end

        S_DONE: begin
          busy[rr] <= 1'b0;
          // The bridge owned the buffer during the transfer, so any
          // modification flagged meanwhile is discarded.
          dirty[rr]      <= 1'b0;
          flush_pend[rr] <= 1'b0;
          if (op != OP_WB) begin
            cur_trk[rr] <= tgt;
            if (op == OP_INIT) pend_init[rr] <= 1'b0;
            rr <= rr_inc(rr);
          end
          // After a write-back rr stays put so the follow-up load is next.
          state <= S_SCAN;
        end

        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_ieeedrv_track_mgr.sv
// Directed bench for ieeedrv_track_mgr with SUBDRV=2, TIMEOUT=8, RETRIES=2.
// The geometry table is a simple arithmetic model driven from geom_trk.
module tb_ieeedrv_track_mgr;

  localparam int SUBDRV = 2;

  logic                    clk_sys = 1'b0;
  logic                    reset;
  logic                    ce;
  logic                    drv_type;
  logic [SUBDRV-1:0]       mounted;
  logic [SUBDRV-1:0][7:0]  req_trk;
  logic [SUBDRV-1:0]       dirty_set;
  logic [SUBDRV-1:0]       flush_req;
  logic [7:0]              geom_trk;
  logic [31:0]             geom_lba;
  logic [5:0]              geom_cnt;
  logic [SUBDRV-1:0][31:0] sd_lba;
  logic [SUBDRV-1:0][5:0]  sd_blk_cnt;
  logic [SUBDRV-1:0]       sd_rd;
  logic [SUBDRV-1:0]       sd_wr;
  logic [SUBDRV-1:0]       sd_ack;
  logic [SUBDRV-1:0][7:0]  cur_trk;
  logic [SUBDRV-1:0]       busy;
  logic [SUBDRV-1:0]       dirty;
  logic [SUBDRV-1:0]       err;

  int   checks = 0;
  int   errors = 0;
  logic multi_req = 1'b0;

  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] lba_of(input logic [7:0] t);
    return 32'h0000_1000 + {24'h0, t} * 32'd64;
  endfunction

  function automatic logic [5:0] cnt_of(input logic [7:0] t);
    return t[5:0] ^ 6'h15;
  endfunction

  assign geom_lba = lba_of(geom_trk);
  assign geom_cnt = cnt_of(geom_trk);

  ieeedrv_track_mgr #(
    .SUBDRV(SUBDRV), .INIT_TRK_8250(8'd39), .INIT_TRK_4040(8'd18),
    .TIMEOUT(8), .RETRIES(2)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .drv_type(drv_type),
    .mounted(mounted), .req_trk(req_trk), .dirty_set(dirty_set),
    .flush_req(flush_req), .geom_trk(geom_trk), .geom_lba(geom_lba),
    .geom_cnt(geom_cnt), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .cur_trk(cur_trk),
    .busy(busy), .dirty(dirty), .err(err)
  );

  // Records any cycle with more than one request bit set.
  always @(negedge clk_sys)
    if (!reset && ($countones({sd_rd, sd_wr}) > 1)) multi_req = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Wait for a request, check it, acknowledge it and let the unit finish.
  task automatic serve(input int u, input bit wr, input logic [7:0] trk, input string tag);
    int n;
    logic [SUBDRV-1:0] one;
    n   = 0;
    one = SUBDRV'(1) << u;
    while ((sd_rd | sd_wr) == '0 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_req_seen"}, 64'(n < 200), 64'd1);
    check({tag, "_sd_wr"}, 64'(sd_wr), wr ? 64'(one) : 64'd0);
    check({tag, "_sd_rd"}, 64'(sd_rd), wr ? 64'd0 : 64'(one));
    check({tag, "_geom_trk"}, 64'(geom_trk), 64'(trk));
    check({tag, "_sd_lba"}, 64'(sd_lba[u]), 64'(lba_of(trk)));
    check({tag, "_blk_cnt"}, 64'(sd_blk_cnt[u]), 64'(cnt_of(trk)));
    check({tag, "_busy"}, 64'(busy[u]), 64'd1);
    @(negedge clk_sys);
    sd_ack[u] = 1'b1;
    @(negedge clk_sys);
    check({tag, "_req_drop"}, 64'(sd_rd | sd_wr), 64'd0);
    @(negedge clk_sys);
    sd_ack[u] = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_dirty(input int u);
    dirty_set[u] = 1'b1;
    @(negedge clk_sys);
    dirty_set[u] = 1'b0;
  endtask

  initial begin
    int n;
    int rises;
    logic prev;

    reset = 1'b1; ce = 1'b1; drv_type = 1'b0; mounted = '0;
    req_trk = '0; dirty_set = '0; flush_req = '0; sd_ack = '0;
    cyc(2);
    check("rst_sd_req", 64'({sd_rd, sd_wr}), 64'd0);
    check("rst_busy_dirty_err", 64'({busy, dirty, err}), 64'd0);
    check("rst_cur_trk", 64'(cur_trk), 64'hFFFF);
    check("rst_geom_trk", 64'(geom_trk), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);

    // Mount unit0 as an 8250: init load of track 39.
    mounted = 2'b01;
    @(negedge clk_sys);
    reset = 1'b0;
    serve(0, 1'b0, 8'd39, "init8250");
    check("init8250_cur_trk", 64'(cur_trk[0]), 64'd39);
    check("init8250_busy", 64'(busy), 64'd0);

    // Dirty buffer then a track change: write back 39, then load 40.
    req_trk[0] = 8'd39;
    cyc(2);
    pulse_dirty(0);
    check("wb_dirty_set", 64'(dirty[0]), 64'd1);
    req_trk[0] = 8'd40;
    serve(0, 1'b1, 8'd39, "wb39");
    serve(0, 1'b0, 8'd40, "load40");
    check("load40_dirty", 64'(dirty[0]), 64'd0);
    check("load40_cur_trk", 64'(cur_trk[0]), 64'd40);

    // Both units mounted together as 4040s: unit0 completes before unit1.
    reset = 1'b1; mounted = 2'b00; req_trk = '0;
    cyc(2);
    drv_type = 1'b1; mounted = 2'b11;
    @(negedge clk_sys);
    reset = 1'b0;
    serve(0, 1'b0, 8'd18, "dual_u0");
    serve(1, 1'b0, 8'd18, "dual_u1");
    check("dual_cur_trk", 64'(cur_trk), 64'h1212);
    check("dual_single_req", 64'(multi_req), 64'd0);

    // Explicit flush of a dirty unit0 at the same track.
    req_trk[0] = 8'd18; req_trk[1] = 8'd18;
    cyc(2);
    pulse_dirty(0);
    check("flush_dirty_set", 64'(dirty[0]), 64'd1);
    flush_req[0] = 1'b1;
    @(negedge clk_sys);
    flush_req[0] = 1'b0;
    serve(0, 1'b1, 8'd18, "flush_wb");
    cyc(2);
    check("flush_dirty_clr", 64'(dirty[0]), 64'd0);
    check("flush_no_reload", 64'({sd_rd, sd_wr}), 64'd0);
    check("flush_cur_trk", 64'(cur_trk[0]), 64'd18);

    // Dirty unit1 unmounted: write-back, then track forgotten; remount reloads.
    pulse_dirty(1);
    check("unmnt_dirty_set", 64'(dirty[1]), 64'd1);
    mounted[1] = 1'b0;
    serve(1, 1'b1, 8'd18, "unmnt_wb");
    cyc(2);
    check("unmnt_cur_trk", 64'(cur_trk[1]), 64'hFF);
    check("unmnt_dirty", 64'(dirty[1]), 64'd0);
    mounted[1] = 1'b1;
    serve(1, 1'b0, 8'd18, "remount");
    check("remount_cur_trk", 64'(cur_trk[1]), 64'd18);

    // Bridge never acknowledges: three requests, then a sticky error.
    req_trk[0] = 8'd20;
    n = 0; rises = 0; prev = 1'b0;
    while (!err[0] && n < 400) begin
      @(negedge clk_sys);
      if (sd_rd[0] && !prev) rises++;
      prev = sd_rd[0];
      n++;
    end
    check("tmo_err_seen", 64'(err[0]), 64'd1);
    check("tmo_req_count", 64'(rises), 64'd3);
    check("tmo_busy", 64'(busy[0]), 64'd0);
    check("tmo_cur_trk", 64'(cur_trk[0]), 64'hFF);
    check("tmo_req_low", 64'(sd_rd[0]), 64'd0);

    // The load is retried later; reset while it waits for the ack.
    n = 0;
    while (!sd_rd[0] && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("rst_wait_req_seen", 64'(sd_rd[0]), 64'd1);
    check("err_sticky", 64'(err[0]), 64'd1);
    cyc(2);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_wait_req", 64'({sd_rd, sd_wr}), 64'd0);
    check("rst_wait_busy", 64'(busy), 64'd0);
    check("rst_wait_cur_trk", 64'(cur_trk), 64'hFFFF);
    check("rst_wait_err", 64'(err), 64'd0);
    check("final_single_req", 64'(multi_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
